// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the arbitrated bus driver.
// Helpers are sized for the largest supported channel count (16).
package bus_arb_pkg;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
    typedef enum logic {IDLE, OWNED} arb_state_e;

    localparam int MAX_M  = 16;
    localparam int MAX_IW = 4;

    function automatic logic [MAX_M-1:0] onehot(input logic [MAX_IW-1:0] idx);
        logic [MAX_M-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_M-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_M; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bus_arbiter_mux_rr_pick.sv
// Combinational winner search: first unmasked request at or after ptr, wrapping.
// Fixed-priority arbitration is the same search with ptr tied to zero.
module rr_pick #(
    parameter  int M  = 5,
    localparam int IW = $clog2(M)
) (
    input  logic [M-1:0]  req_i,
    input  logic [M-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] win_o,
    output logic          found_o
);

    logic [M-1:0] cand;
    int           idx;

    // Scan from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        cand    = req_i & ~mask_i;
        win_o   = '0;
        found_o = 1'b0;
        idx     = 0;
        for (int k = M - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= M) begin
                idx = idx - M;
            end
            if (cand[idx[IW-1:0]]) begin
                win_o   = idx[IW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered M-channel bus driver with request arbitration, bounded hold time
// and a saturating contention counter for debug.
module bus_arbiter_mux
    import bus_arb_pkg::*;
#(
    parameter int        N        = 16,
    parameter int        M        = 5,
    parameter arb_mode_e MODE     = ARB_RR,
    parameter int        MAX_HOLD = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [M-1:0] req_i,
    input  logic [N-1:0] in_i [M],
    output logic [N-1:0] out_o,
    output logic [M-1:0] grant_o,
    output logic         valid_o,
    output logic [7:0]   conflict_cnt_o
);

    localparam int IW       = $clog2(M);
    localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_SAT + 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [M-1:0]      grant_q, grant_d;
    logic [N-1:0]      out_q, out_d;
    logic              valid_q, valid_d;
    logic [7:0]        conf_q, conf_d;

    logic [M-1:0]      owner_oh;
    logic [M-1:0]      others;
    logic [M-1:0]      pick_mask;
    logic [IW-1:0]     pick_ptr;
    logic [IW-1:0]     win;
    logic              found;
    logic              forced;
    logic              grant_now;

    rr_pick #(.M(M)) u_pick (
        .req_i   (req_i),
        .mask_i  (pick_mask),
        .ptr_i   (pick_ptr),
        .win_o   (win),
        .found_o (found)
    );

    always_comb begin
        owner_oh  = M'(onehot(MAX_IW'(owner_q)));
        others    = req_i & ~owner_oh;
        pick_mask = (state_q == OWNED) ? owner_oh : '0;
        pick_ptr  = (MODE == ARB_FIXED) ? '0 : ptr_q;
        forced    = (MAX_HOLD != 0) && (hold_q == HOLD_W'(HOLD_SAT)) && (others != '0);
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_now = 1'b1;
                end
            end
            OWNED: begin
                if (req_i[owner_q] && !forced) begin
                    if (hold_q != HOLD_W'(HOLD_SAT)) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (found) begin
                    // Owner is masked, so the winner is always a different channel.
                    grant_now = 1'b1;
                end else begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_now) begin
            state_d = OWNED;
            owner_d = win;
            hold_d  = HOLD_W'(1);
            ptr_d   = (win == IW'(M - 1)) ? '0 : win + 1'b1;
        end

        // Outputs are computed from the next-state owner so Out and Grant share an edge.
        if (state_d == OWNED) begin
            grant_d = M'(onehot(MAX_IW'(owner_d)));
            out_d   = in_i[owner_d];
            valid_d = 1'b1;
        end else begin
            grant_d = '0;
            out_d   = '0;
            valid_d = 1'b0;
        end

        conf_d = conf_q;
        if (popcount(MAX_M'(req_i)) > 5'd1 && conf_q != 8'hFF) begin
            conf_d = conf_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            conf_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            conf_q  <= conf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(grant_q));
        end
    end

    assign out_o          = out_q;
    assign grant_o        = grant_q;
    assign valid_o        = valid_q;
    assign conflict_cnt_o = conf_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: a round-robin instance and a fixed-priority
// instance share one set of stimulus.
module tb_bus_arbiter_mux;
    import bus_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  req = '0;
    logic [15:0] din [5];

    logic [15:0] rr_out, fx_out;
    logic [4:0]  rr_grant, fx_grant;
    logic        rr_valid, fx_valid;
    logic [7:0]  rr_cnt, fx_cnt;

    int errors = 0;
    int checks = 0;

    bus_arbiter_mux #(.N(16), .M(5), .MODE(ARB_RR), .MAX_HOLD(8)) u_rr (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .in_i           (din),
        .out_o          (rr_out),
        .grant_o        (rr_grant),
        .valid_o        (rr_valid),
        .conflict_cnt_o (rr_cnt)
    );

    bus_arbiter_mux #(.N(16), .M(5), .MODE(ARB_FIXED), .MAX_HOLD(8)) u_fx (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .in_i           (din),
        .out_o          (fx_out),
        .grant_o        (fx_grant),
        .valid_o        (fx_valid),
        .conflict_cnt_o (fx_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 5'b00000;
        do_reset();
        checks++; if (rr_grant !== 5'b0) begin errors++; $display("FAIL reset_grant got=%b exp=%b", rr_grant, 5'b0); end
        checks++; if (rr_out !== 16'h0) begin errors++; $display("FAIL reset_out got=%h exp=%h", rr_out, 16'h0); end
        checks++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rr_valid); end
        checks++; if (rr_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", rr_cnt); end
        checks++; if (fx_grant !== 5'b0) begin errors++; $display("FAIL reset_fx_grant got=%b exp=%b", fx_grant, 5'b0); end
    endtask

    task automatic test_single();
        din[2] = 16'hBEEF;
        req    = 5'b00100;
        tick();
        checks++; if (rr_grant !== 5'b00100) begin errors++; $display("FAIL single_grant got=%b exp=%b", rr_grant, 5'b00100); end
        checks++; if (rr_out !== 16'hBEEF) begin errors++; $display("FAIL single_out got=%h exp=%h", rr_out, 16'hBEEF); end
        checks++; if (rr_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", rr_valid); end
        din[2] = 16'h1234;
        tick();
        checks++; if (rr_out !== 16'h1234) begin errors++; $display("FAIL single_track got=%h exp=%h", rr_out, 16'h1234); end
        req = 5'b00000;
        tick();
        checks++; if (rr_grant !== 5'b0) begin errors++; $display("FAIL single_rel_grant got=%b exp=%b", rr_grant, 5'b0); end
        checks++; if (rr_out !== 16'h0) begin errors++; $display("FAIL single_rel_out got=%h exp=%h", rr_out, 16'h0); end
        checks++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL single_rel_valid got=%b exp=0", rr_valid); end
        checks++; if (rr_cnt !== 8'd0) begin errors++; $display("FAIL single_cnt got=%0d exp=0", rr_cnt); end
    endtask

    task automatic test_rr_wrap();
        logic [4:0] exp_g;
        int         e;
        do_reset();
        req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick();
            e     = k % 5;
            exp_g = 5'(1 << e);
            checks++; if (rr_grant !== exp_g) begin errors++; $display("FAIL rr_grant step=%0d got=%b exp=%b", k, rr_grant, exp_g); end
            checks++; if (rr_out !== din[e]) begin errors++; $display("FAIL rr_out step=%0d got=%h exp=%h", k, rr_out, din[e]); end
            checks++; if (rr_cnt !== 8'(k + 1)) begin errors++; $display("FAIL rr_cnt step=%0d got=%0d exp=%0d", k, rr_cnt, k + 1); end
            req = 5'b11111 & ~exp_g;
        end
        req = 5'b00000;
        tick();
    endtask

    task automatic test_fixed();
        do_reset();
        req = 5'b10110;
        tick();
        checks++; if (fx_grant !== 5'b00010) begin errors++; $display("FAIL fx_grant1 got=%b exp=%b", fx_grant, 5'b00010); end
        checks++; if (fx_out !== din[1]) begin errors++; $display("FAIL fx_out1 got=%h exp=%h", fx_out, din[1]); end
        req = 5'b10100;
        tick();
        checks++; if (fx_grant !== 5'b00100) begin errors++; $display("FAIL fx_grant2 got=%b exp=%b", fx_grant, 5'b00100); end
        checks++; if (fx_valid !== 1'b1) begin errors++; $display("FAIL fx_valid2 got=%b exp=1", fx_valid); end
        checks++; if (fx_out !== din[2]) begin errors++; $display("FAIL fx_out2 got=%h exp=%h", fx_out, din[2]); end
        req = 5'b10000;
        tick();
        checks++; if (fx_grant !== 5'b10000) begin errors++; $display("FAIL fx_grant3 got=%b exp=%b", fx_grant, 5'b10000); end
        req = 5'b00000;
        tick();
    endtask

    task automatic test_max_hold();
        do_reset();
        req = 5'b00001;
        tick();
        checks++; if (rr_grant !== 5'b00001) begin errors++; $display("FAIL hold_first got=%b exp=%b", rr_grant, 5'b00001); end
        req = 5'b01001;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++; if (rr_grant !== 5'b00001) begin errors++; $display("FAIL hold_keep cyc=%0d got=%b exp=%b", k + 2, rr_grant, 5'b00001); end
        end
        tick();
        checks++; if (rr_grant !== 5'b01000) begin errors++; $display("FAIL hold_forced got=%b exp=%b", rr_grant, 5'b01000); end
        checks++; if (rr_out !== din[3]) begin errors++; $display("FAIL hold_forced_out got=%h exp=%h", rr_out, din[3]); end
        checks++; if (rr_cnt !== 8'd8) begin errors++; $display("FAIL hold_cnt got=%0d exp=8", rr_cnt); end
        req = 5'b00000;
        tick();
        do_reset();
        req = 5'b00001;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++; if (rr_grant !== 5'b00001) begin errors++; $display("FAIL hold_alone cyc=%0d got=%b exp=%b", k + 1, rr_grant, 5'b00001); end
        end
        req = 5'b00000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 5'b11111;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if (rr_grant !== 5'b0) begin errors++; $display("FAIL mid_grant got=%b exp=%b", rr_grant, 5'b0); end
        checks++; if (rr_out !== 16'h0) begin errors++; $display("FAIL mid_out got=%h exp=%h", rr_out, 16'h0); end
        checks++; if (rr_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", rr_cnt); end
        checks++; if (u_rr.ptr_q !== 3'd0) begin errors++; $display("FAIL mid_ptr got=%0d exp=0", u_rr.ptr_q); end
        rst = 1'b0;
        tick();
        checks++; if (rr_grant !== 5'b00001) begin errors++; $display("FAIL mid_regrant got=%b exp=%b", rr_grant, 5'b00001); end
        checks++; if (rr_cnt !== 8'd1) begin errors++; $display("FAIL mid_cnt2 got=%0d exp=1", rr_cnt); end
        req = 5'b00000;
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        req = 5'b00011;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) begin
                checks++; if (rr_cnt !== 8'd254) begin errors++; $display("FAIL sat_pre got=%0d exp=254", rr_cnt); end
            end
        end
        checks++; if (rr_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", rr_cnt); end
        checks++; if (fx_cnt !== 8'd255) begin errors++; $display("FAIL sat_fx_final got=%0d exp=255", fx_cnt); end
        req = 5'b00000;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            din[i] = 16'hA000 + 16'(i * 16'h0111);
        end
        #2;
        test_reset();
        test_single();
        test_rr_wrap();
        test_fixed();
        test_max_hold();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Registered, parametrised bus driver that generalises the one-hot datapath bus mux to M requesting channels of N-bit data, with built-in arbitration. Channels raise requests instead of a control unit supplying a one-hot select; the block grants exactly one owner, drives its data onto the shared bus, holds ownership while the request stays high, and enforces a maximum hold time so no channel starves. It sits between datapath sources (PC, MAR/MDR, ALU, address adder, I/O) and the CPU bus, and reports contention for debug.

## Interface
- N, 16: data width.
- M, 5: channel count, 2..16.
- MODE, ARB_RR: ARB_RR is round-robin; ARB_FIXED gives the lowest index highest priority.
- MAX_HOLD, 8: consecutive owned cycles before a forced release when other channels wait. 0 disables the limit.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  M  per-channel bus request.
- In  in  M x N  unpacked array of channel data; In[i] belongs to Req[i].
- Out  out  N  registered bus value; zero when not Valid.
- Grant  out  M  registered one-hot owner; all-zero when idle.
- Valid  out  1  registered; high when Grant is non-zero.
- ConflictCnt  out  8  saturating count of cycles with more than one Req bit set.

## Operation
- State machine: IDLE, OWNED.
- IDLE: if Req == 0, stay; Grant, Out and Valid are 0. Otherwise pick a winner, go to OWNED, Grant = onehot(winner), hold count = 1.
- Winner, ARB_FIXED: lowest set Req index.
- Winner, ARB_RR: first set Req index at or after ptr, wrapping modulo M. On every new grant, ptr = winner + 1 mod M. Wrap from M-1 to 0 is required.
- OWNED, owner's Req still high and no forced release: stay, hold count increments and saturates.
- OWNED, owner's Req low: release. If other Req bits are set, re-arbitrate in the same cycle with no idle gap (owner excluded, since its Req is 0). Otherwise go to IDLE.
- Forced release: MAX_HOLD != 0, hold count == MAX_HOLD, and any other Req bit is set. Re-arbitrate with the owner masked out. The new owner is granted on the next edge with no gap.
- If no other channel waits, the owner keeps the bus indefinitely. The hold count saturates at MAX_HOLD.
- Out is registered every cycle from In[owner] as it will be next cycle, so data tracks live In while owned. The owner is the next-state owner.
- ConflictCnt increments when popcount(Req) > 1 and saturates at 255.
- Reset returns the block to IDLE, ptr = 0, hold count = 0, Grant = 0, Out = 0, Valid = 0, ConflictCnt = 0. This applies mid-ownership too, and reset overrides every other event in that cycle.

## Timing
- Latency: Req rising at cycle t gives Grant, Valid and Out at t+1 (one register stage).
- Release: owner's Req falling at t gives a new Grant, or idle, at t+1.
- The Out/Grant relationship is cycle-exact: Out always equals the data of the channel shown in Grant, sampled on the same edge.
- Simultaneous release and new requests are resolved in one cycle.
- Grant is never multi-hot and never changes except on a Clk edge.

## Structure
- Package bus_arb_pkg holds:
  - arb_mode_e {ARB_RR, ARB_FIXED}
  - arb_state_e {IDLE, OWNED}
  - the onehot and popcount helper functions.
- Sub-module rr_pick #(M): combinational. Inputs are Req, Mask and Ptr; outputs are the winner index and Found. It serves both modes, with ARB_FIXED passing Ptr = 0.
- The rest (state, ptr, hold counter, output registers, conflict counter) lives in bus_arbiter_mux.

## Test plan
- Reset, then Req=00100 and In[2]=16'hBEEF: after one cycle Grant=00100, Out=BEEF, Valid=1. Drop Req: the next cycle gives Grant=0, Out=0.
- ARB_RR with Req=11111 held and each owner dropping its Req for one cycle after its grant: grants go 0,1,2,3,4,0 (wrap). ConflictCnt increments on each cycle with multiple Req bits set.
- ARB_FIXED with Req=10110: Grant=00010. Owner 1 drops: Grant=00100 on the next edge with no idle cycle.
- MAX_HOLD=8 with channel 0 holding and channel 3 requesting from cycle 2: Grant=00001 for 8 cycles, then 01000. With channel 0 alone, it holds for 20 cycles and Grant never changes.
- Reset asserted during OWNED with Req=11111: the next cycle gives Grant=0, Out=0, ConflictCnt=0, ptr=0. Deasserting reset yields Grant=00001 in ARB_RR.
- Hold Req=00011 for 300 cycles: ConflictCnt saturates at 255 and does not wrap.
